// File: rtl/hsi_tx_arb_pkg.sv
// Shared definitions for the HSI transmit-side coder arbiter.
// Holds arbiter state encodings and default gap/watchdog constants.
package hsi_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    localparam int HSI_GAP_CYCLES = 4;
    localparam int HSI_TIMEOUT    = 4096;
    localparam int HSI_CNT_W      = 13;

endpackage

// File: rtl/hsi_arb_rr2.sv
// Two-way round-robin pick: returns the index to grant.
// Ports: req0/req1 requests, last previously granted index; any, idx.
module hsi_arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic idx
);

    assign any = req0 | req1;
    // On a tie the side that did not go last wins.
    assign idx = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/hsi_tx_arb.sv
// Message-granular round-robin arbiter for the shared HSI byte coder.
// Ports: clk, rst; per side req/gnt/q/q_rdy/msg_end/busy; cd_* coder
// interface; to_err watchdog pulse; active while a grant is held.
module hsi_tx_arb
    import hsi_tx_arb_pkg::*;
#(
    parameter int GAP_CYCLES = HSI_GAP_CYCLES,
    parameter int TIMEOUT    = HSI_TIMEOUT,
    parameter int CNT_W      = HSI_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    output logic       gnt0,
    input  logic [7:0] q0,
    input  logic       q_rdy0,
    input  logic       msg_end0,
    output logic       busy0,
    input  logic       req1,
    output logic       gnt1,
    input  logic [7:0] q1,
    input  logic       q_rdy1,
    input  logic       msg_end1,
    output logic       busy1,
    output logic [7:0] cd_d,
    output logic       cd_d_rdy,
    input  logic       cd_busy,
    output logic       to_err,
    output logic       active
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             last_q, last_d;
    logic             own_q, own_d;
    logic             to_err_q, to_err_d;

    logic             pick_any, pick_idx;
    logic             granted;
    logic             own_rdy, own_end;
    logic [7:0]       own_byte;

    hsi_arb_rr2 u_rr2 (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign granted  = (state_q == ARB_GRANT);
    assign own_rdy  = own_q ? q_rdy1   : q_rdy0;
    assign own_end  = own_q ? msg_end1 : msg_end0;
    assign own_byte = own_q ? q1       : q0;
    // Saturating increment keeps the counter from wrapping.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        own_d    = own_q;
        to_err_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    own_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                // msg_end takes precedence over the watchdog.
                if (own_end) begin
                    state_d = ARB_GAP;
                    cnt_d   = '0;
                end else if (own_rdy) begin
                    cnt_d = '0;
                end else if (cnt_q >= TO_LAST) begin
                    state_d  = ARB_GAP;
                    cnt_d    = '0;
                    to_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ARB_GAP: begin
                // Gap count only starts once the coder has drained.
                if (cd_busy) begin
                    cnt_d = '0;
                end else if (cnt_q >= GAP_LAST) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            own_q    <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            own_q    <= own_d;
            to_err_q <= to_err_d;
        end
    end

    assign gnt0     = granted & ~own_q;
    assign gnt1     = granted &  own_q;
    assign active   = granted;
    assign to_err   = to_err_q;
    assign cd_d     = granted ? own_byte : 8'h00;
    // Reset is synchronous, so gate the strobe while it is asserted.
    assign cd_d_rdy = granted & own_rdy & ~rst;
    assign busy0    = gnt0 ? cd_busy : 1'b1;
    assign busy1    = gnt1 ? cd_busy : 1'b1;

endmodule
